printf_line_arbiter: RTL



---
 rtl/printf_line_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/printf_line_arbiter.sv
// Line-granular round-robin arbiter sharing one printf UART TX byte channel among NUM_REQ requesters.
// An owner keeps the channel until it sends LINE_END or stays silent for TIMEOUT_CYCLES.
module printf_line_arbiter #(
  parameter int                 NUM_REQ        = 4,
  parameter int                 BW_DATA        = 8,
  parameter logic [BW_DATA-1:0] LINE_END       = 8'h0A,
  parameter int                 TIMEOUT_CYCLES = 1024,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BW_DATA-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [BW_DATA-1:0]         tx_data,
  input  logic                       tx_ready,
  output logic [GW-1:0]              grant_id,
  output logic                       busy
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      pick;
  logic [GW:0]        scan_idx;
  logic [TW-1:0]      tmo_cnt;
  logic               sel_valid;
  logic [BW_DATA-1:0] sel_data;
  logic               xfer;
  logic               line_done;
  logic               tmo_hit;
  logic               release_now;

  // Scan from the highest offset down so the requester closest to rr_ptr is the last writer and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    pick     = rr_ptr;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (GW+1)'(k);
      if (scan_idx >= (GW+1)'(NUM_REQ)) scan_idx = scan_idx - (GW+1)'(NUM_REQ);
      if (req_valid[scan_idx[GW-1:0]]) pick = scan_idx[GW-1:0];
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*BW_DATA +: BW_DATA];
      end
    end
  end

  // NOTE: the owner's path to the UART is deliberately combinational so a byte moves in the cycle tx_ready is seen.
  assign tx_valid = (state == LOCKED) && sel_valid;
  assign tx_data  = (state == LOCKED) ? sel_data : '0;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == LOCKED) && (grant_id == GW'(i)) && tx_ready;
    end
  end

  assign xfer        = tx_valid && tx_ready;
  assign line_done   = xfer && (tx_data == LINE_END);
  // Silence means the owner has nothing to send; a held byte under backpressure never counts.
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (state == LOCKED) && !sel_valid && (tmo_cnt == TMO_LAST);
  assign release_now = line_done || tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      tmo_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            tmo_cnt  <= '0;
            state    <= LOCKED;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (release_now) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
          end
          if (xfer) begin
            tmo_cnt <= '0;
          end else if (!sel_valid && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
